// File: rtl/cla_pipe_adder_pkg.sv
// cla_pipe_adder_pkg
//   Shared definitions for the pipelined carry-lookahead adder/accumulator:
//   op encodings, an accumulator-writer predicate and the parameter
//   legality check used by the top level at elaboration time.
package cla_pipe_adder_pkg;

  // Operation encodings on the 2-bit op port.
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  // ACC and LOAD results are written into the accumulator on transfer.
  function automatic logic op_writes_acc(input logic [1:0] opc);
    return (opc == OP_ACC) || (opc == OP_LOAD);
  endfunction

  // WIDTH must split evenly into STAGES slices of whole 4-bit groups.
  function automatic bit cla_params_ok(input int unsigned width, input int unsigned stages);
    return (width >= 8) && (width % 4 == 0) && (stages >= 1) &&
           (width % (4 * stages) == 0);
  endfunction

endpackage

// File: rtl/cla_pipe_adder_group4.sv
// cla_group4
//   4-bit full carry-lookahead adder group. All four internal carries and
//   the group carry-out are computed directly from propagate/generate terms
//   and the group carry-in, with no internal ripple.
// Ports:
//   a, b  in  4  addend bits
//   cin   in  1  group carry-in
//   s     out 4  sum bits
//   cout  out 1  carry out of bit 3
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
           (p[3] & p[2] & p[1] & p[0] & cin);
  end

  assign s = p ^ c;

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder
//   Pipelined carry-lookahead adder/accumulator. The WIDTH-bit add is split
//   into STAGES slices; each slice is a chain of 4-bit lookahead groups and
//   the carry between slices is registered. Stage s works on slice s one
//   cycle after stage s-1, so unused upper operand bits travel down the
//   pipeline (skew) and finished lower sum bits travel alongside (deskew).
//   Result latency is STAGES cycles, throughput one op per cycle.
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   in_valid/in_ready operation handshake; op/a/b/cin are the operation
//   out_valid/out_ready result handshake; sum/cout/ovf are the result
//   acc               current accumulator value
module cla_pipe_adder
  import cla_pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] acc
);

  localparam int unsigned NG  = WIDTH / 4;     // total lookahead groups
  localparam int unsigned GPS = NG / STAGES;   // groups per stage
  localparam int unsigned SW  = 4 * GPS;       // slice width per stage
  localparam int unsigned LST = STAGES - 1;

  if (!cla_params_ok(WIDTH, STAGES)) begin : gen_param_check
    $error("cla_pipe_adder: WIDTH must be >= 8 and a multiple of 4*STAGES");
  end

  // Pipeline registers, one entry per stage. x_q/y_q hold the operand bits
  // still to be added, shifted so the next stage's slice sits at bit 0.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [1:0]        op_q [STAGES];
  logic [WIDTH-1:0]  x_q  [STAGES];
  logic [WIDTH-1:0]  y_q  [STAGES];
  logic [WIDTH-1:0]  s_q  [STAGES];
  logic              ovf_q;
  logic [WIDTH-1:0]  acc_q;

  // Handshake / interlock.
  logic stall;
  logic acc_busy;
  logic hazard;
  logic accept;

  // Effective operands for the op being offered.
  logic [WIDTH-1:0] eff_x;
  logic [WIDTH-1:0] eff_y;
  logic             eff_c;

  // Per-stage combinational inputs and results.
  logic [WIDTH-1:0]  stg_x [STAGES];
  logic [WIDTH-1:0]  stg_y [STAGES];
  logic [WIDTH-1:0]  stg_s [STAGES];
  logic [1:0]        stg_op [STAGES];
  logic [STAGES-1:0] stg_v;
  logic [STAGES-1:0] stg_c;
  logic [STAGES-1:0] stage_co;
  logic [WIDTH-1:0]  grp_s;
  logic [WIDTH-1:0]  nx_s [STAGES];
  logic              ovf_d;

  // ---------------------------------------------------------------------------
  // Interlock and handshake
  // ---------------------------------------------------------------------------
  assign stall = v_q[LST] & ~out_ready;

  // Any ACC/LOAD in flight (including the one at the output) makes acc stale.
  always_comb begin
    acc_busy = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (v_q[k] && op_writes_acc(op_q[k])) acc_busy = 1'b1;
    end
  end

  assign hazard   = in_valid & (op == OP_ACC) & acc_busy;
  assign in_ready = ~rst & ~stall & ~hazard;
  assign accept   = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Operand selection
  // ---------------------------------------------------------------------------
  always_comb begin
    eff_x = a;
    eff_y = b;
    eff_c = 1'b0;
    case (op)
      OP_ADD: eff_c = cin;
      OP_SUB: begin
        eff_y = ~b;
        eff_c = 1'b1;
      end
      OP_ACC: begin
        eff_x = acc_q;
        eff_y = a;
      end
      OP_LOAD: eff_y = '0;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage inputs: stage 0 takes the new op, later stages take the register
  // of the stage before.
  // ---------------------------------------------------------------------------
  always_comb begin
    stg_x[0]  = eff_x;
    stg_y[0]  = eff_y;
    stg_s[0]  = '0;
    stg_op[0] = op;
    stg_v[0]  = accept;
    stg_c[0]  = eff_c;
    for (int k = 1; k < STAGES; k++) begin
      stg_x[k]  = x_q[k-1];
      stg_y[k]  = y_q[k-1];
      stg_s[k]  = s_q[k-1];
      stg_op[k] = op_q[k-1];
      stg_v[k]  = v_q[k-1];
      stg_c[k]  = c_q[k-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Lookahead groups. Group g belongs to stage g/GPS and handles bits
  // [4*(g%GPS)+3 : 4*(g%GPS)] of that stage's slice. Carries ripple between
  // groups inside a stage; the last group's carry-out leaves the stage.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NG; g++) begin : gen_grp
    localparam int unsigned S = g / GPS;
    localparam int unsigned L = g % GPS;
    logic ci;
    logic co;

    if (L == 0) begin : gen_first
      assign ci = stg_c[S];
    end else begin : gen_chain
      assign ci = gen_grp[g-1].co;
    end

    if (L == GPS - 1) begin : gen_last
      assign stage_co[S] = co;
    end

    cla_group4 u_grp (
      .a    (stg_x[S][4*L +: 4]),
      .b    (stg_y[S][4*L +: 4]),
      .cin  (ci),
      .s    (grp_s[4*g +: 4]),
      .cout (co)
    );
  end

  // Merge each stage's new slice into the sum bits carried from earlier stages.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      nx_s[k]            = stg_s[k];
      nx_s[k][k*SW +: SW] = grp_s[k*SW +: SW];
    end
  end

  // The MSB lives in the last stage's slice, so overflow is decided there.
  assign ovf_d = (stg_x[LST][SW-1] == stg_y[LST][SW-1]) &&
                 (grp_s[WIDTH-1] != stg_x[LST][SW-1]);

  // ---------------------------------------------------------------------------
  // Stage registers: everything holds while the output is stalled; bubbles
  // advance like real ops otherwise.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        op_q[k] <= OP_ADD;
        x_q[k]  <= '0;
        y_q[k]  <= '0;
        s_q[k]  <= '0;
      end
    end else if (!stall) begin
      v_q   <= stg_v;
      c_q   <= stage_co;
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        op_q[k] <= stg_op[k];
        x_q[k]  <= stg_x[k] >> SW;
        y_q[k]  <= stg_y[k] >> SW;
        s_q[k]  <= nx_s[k];
      end
    end
  end

  // Accumulator only changes when an ACC/LOAD result actually transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (v_q[LST] && out_ready && op_writes_acc(op_q[LST])) begin
      acc_q <= s_q[LST];
    end
  end

  assign out_valid = v_q[LST];
  assign sum       = s_q[LST];
  assign cout      = c_q[LST];
  assign ovf       = ovf_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=16, STAGES=2). Inputs are
// driven 1 time unit after the rising edge and outputs sampled 2 units after.
module tb_cla_pipe_adder;

  localparam int unsigned W = 16;
  localparam logic [1:0] ADD  = 2'b00;
  localparam logic [1:0] SUB  = 2'b01;
  localparam logic [1:0] ACC  = 2'b10;
  localparam logic [1:0] LOAD = 2'b11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = ADD;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [W-1:0] acc;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W+1:0] res;
  } exp_t;

  always #5 clk = ~clk;

  cla_pipe_adder #(
    .WIDTH  (W),
    .STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .acc       (acc)
  );

  // Reference: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] golden(input logic [1:0] o, input logic [W-1:0] aa,
                                          input logic [W-1:0] bb, input logic c,
                                          input logic [W-1:0] acc_v);
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         c0;
    logic [W:0]   full;
    logic         v;
    case (o)
      ADD:     begin x = aa;    y = bb;  c0 = c;    end
      SUB:     begin x = aa;    y = ~bb; c0 = 1'b1; end
      ACC:     begin x = acc_v; y = aa;  c0 = 1'b0; end
      default: begin x = aa;    y = '0;  c0 = 1'b0; end
    endcase
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c0};
    v = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {v, full};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] o, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic c);
    in_valid = v;
    op       = o;
    a        = aa;
    b        = bb;
    cin      = c;
  endtask

  task automatic test_reset();
    tick();
    drive(1'b1, ADD, 16'h1234, 16'h1111, 1'b0);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++;
    if (sum !== '0) begin miscompares++; $display("FAIL reset_sum: got %h want 0000", sum); end
    vectors++;
    if ({cout, ovf} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got cout=%b ovf=%b want 0 0", cout, ovf); end
    vectors++;
    if (acc !== '0) begin miscompares++; $display("FAIL reset_acc: got %h want 0000", acc); end
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_no_leak: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_directed();
    logic [1:0]   t_op [7] = '{ADD, SUB, ADD, ADD, SUB, SUB, ADD};
    logic [W-1:0] t_a  [7] = '{16'h00FF, 16'h0000, 16'h7FFF, 16'hFFFF, 16'h0005, 16'h8000, 16'h0F0F};
    logic [W-1:0] t_b  [7] = '{16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0003, 16'h0001, 16'h00F1};
    logic         t_c  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [W+1:0] t_e  [7] = '{{2'b00, 16'h0100}, {2'b00, 16'hFFFF}, {2'b10, 16'h8000},
                               {2'b01, 16'h0000}, {2'b01, 16'h0002}, {2'b11, 16'h7FFF},
                               {2'b00, 16'h1000}};
    for (int i = 0; i < 7; i++) begin
      logic got;
      int   lat;
      drive(1'b1, t_op[i], t_a[i], t_b[i], t_c[i]);
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready); end
      tick();
      in_valid = 1'b0;
      got = 1'b0;
      lat = 0;
      for (int n = 0; n < 6 && !got; n++) begin
        #1;
        lat++;
        if (out_valid) got = 1'b1;
        else tick();
      end
      vectors++;
      if (!got) begin
        miscompares++;
        $display("FAIL dir%0d_timeout: got no out_valid want result within 6 cycles", i);
      end else begin
        if ({ovf, cout, sum} !== t_e[i]) begin
          miscompares++;
          $display("FAIL dir%0d_result: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                   i, ovf, cout, sum, t_e[i][W+1], t_e[i][W], t_e[i][W-1:0]);
        end
        vectors++;
        if (lat != 2) begin miscompares++; $display("FAIL dir%0d_latency: got %0d want 2", i, lat); end
        tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] e [8];
    int idx = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc < 8) begin
        logic [W-1:0] aa;
        logic [W-1:0] bb;
        aa = W'($urandom);
        bb = W'($urandom);
        e[cyc] = golden(ADD, aa, bb, 1'b0, '0);
        drive(1'b1, ADD, aa, bb, 1'b0);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc < 8) begin
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready%0d: got %b want 1", cyc, in_ready); end
      end
      if (out_valid) begin
        vectors++;
        if (idx >= 8) begin
          miscompares++;
          $display("FAIL b2b_extra: got result %h want none", sum);
        end else begin
          if ({ovf, cout, sum} !== e[idx]) begin
            miscompares++;
            $display("FAIL b2b_result%0d: got %h want %h", idx, {ovf, cout, sum}, e[idx]);
          end
          vectors++;
          if (cyc != idx + 2) begin miscompares++; $display("FAIL b2b_timing%0d: got cycle %0d want %0d", idx, cyc, idx + 2); end
          idx++;
        end
      end
      tick();
    end
    vectors++;
    if (idx != 8) begin miscompares++; $display("FAIL b2b_count: got %0d want 8", idx); end
  endtask

  task automatic test_acc_hazard();
    logic [1:0]   s_op  [7]  = '{LOAD, ACC, ADD, ACC, ACC, ACC, ACC};
    logic [W-1:0] s_a   [7]  = '{16'h0010, 16'h0005, 16'h0001, 16'h0005, 16'h0001, 16'h0001, 16'h0001};
    logic [W-1:0] s_b   [7]  = '{16'h0000, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic         s_rdy [7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic         e_ov  [10] = '{0, 0, 1, 0, 1, 1, 0, 0, 1, 0};
    logic [W-1:0] e_sum [10] = '{0, 0, 16'h0010, 0, 16'h0003, 16'h0015, 0, 0, 16'h0016, 0};
    logic [W-1:0] e_acc [10] = '{0, 0, 0, 16'h0010, 16'h0010, 16'h0010, 16'h0015, 16'h0015,
                                 16'h0015, 16'h0016};
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc < 7) drive(1'b1, s_op[cyc], s_a[cyc], s_b[cyc], 1'b0);
      else in_valid = 1'b0;
      #1;
      if (cyc < 7) begin
        vectors++;
        if (in_ready !== s_rdy[cyc]) begin
          miscompares++;
          $display("FAIL hazard_ready%0d: got %b want %b", cyc, in_ready, s_rdy[cyc]);
        end
      end
      vectors++;
      if (acc !== e_acc[cyc]) begin miscompares++; $display("FAIL hazard_acc%0d: got %h want %h", cyc, acc, e_acc[cyc]); end
      vectors++;
      if (out_valid !== e_ov[cyc] || (e_ov[cyc] && sum !== e_sum[cyc])) begin
        miscompares++;
        $display("FAIL hazard_out%0d: got valid=%b sum=%h want valid=%b sum=%h",
                 cyc, out_valid, sum, e_ov[cyc], e_sum[cyc]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] e1;
    logic [W+1:0] e2;
    e1 = golden(ADD, 16'h1234, 16'h1111, 1'b0, '0);
    e2 = golden(ADD, 16'hFFFF, 16'h0002, 1'b0, '0);
    out_ready = 1'b1;
    drive(1'b1, ADD, 16'h1234, 16'h1111, 1'b0);
    tick();
    drive(1'b1, ADD, 16'hFFFF, 16'h0002, 1'b0);
    tick();
    for (int cyc = 2; cyc < 8; cyc++) begin
      out_ready = (cyc >= 5);
      if (cyc < 5) drive(1'b1, ADD, 16'h0AAA, 16'h0000, 1'b0);
      else in_valid = 1'b0;
      #1;
      if (cyc < 5) begin
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready%0d: got %b want 0", cyc, in_ready); end
      end
      vectors++;
      if (cyc <= 5) begin
        if (out_valid !== 1'b1 || {ovf, cout, sum} !== e1) begin
          miscompares++;
          $display("FAIL bp_hold%0d: got valid=%b res=%h want valid=1 res=%h", cyc, out_valid, {ovf, cout, sum}, e1);
        end
      end else if (cyc == 6) begin
        if (out_valid !== 1'b1 || {ovf, cout, sum} !== e2) begin
          miscompares++;
          $display("FAIL bp_second: got valid=%b res=%h want valid=1 res=%h", out_valid, {ovf, cout, sum}, e2);
        end
      end else begin
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drained: got valid=%b want 0", out_valid); end
      end
      tick();
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_midstream();
    logic got;
    out_ready = 1'b1;
    drive(1'b1, LOAD, 16'h0007, 16'h0000, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    drive(1'b1, ACC, 16'h0001, 16'h0000, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b1 || acc !== 16'h0007 || sum !== 16'h0008) begin
      miscompares++;
      $display("FAIL rst_pre: got valid=%b acc=%h sum=%h want 1 0007 0008", out_valid, acc, sum);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || acc !== '0 || sum !== '0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async: got valid=%b acc=%h sum=%h ready=%b want 0 0000 0000 0",
               out_valid, acc, sum, in_ready);
    end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, ACC, 16'h0003, 16'h0000, 1'b0);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_after_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 6 && !got; n++) begin
      #1;
      if (out_valid) got = 1'b1;
      else tick();
    end
    vectors++;
    if (!got || sum !== 16'h0003) begin
      miscompares++;
      $display("FAIL rst_after_result: got valid=%b sum=%h want 1 0003", got, sum);
    end
    tick();
    vectors++;
    if (acc !== 16'h0003) begin miscompares++; $display("FAIL rst_after_acc: got %h want 0003", acc); end
  endtask

  task automatic test_random();
    exp_t         q[$];
    logic [W-1:0] m_acc;
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    m_acc = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic busy;
      logic exp_ready;
      exp_t e;
      drive(($urandom_range(0, 9) < 7), 2'($urandom), W'($urandom), W'($urandom), 1'($urandom));
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      vectors++;
      if (acc !== m_acc) begin miscompares++; $display("FAIL rnd_acc@%0d: got %h want %h", cyc, acc, m_acc); end
      busy = 1'b0;
      foreach (q[i]) if (q[i].op[1]) busy = 1'b1;
      exp_ready = !(out_valid && !out_ready) && !(in_valid && op == ACC && busy);
      vectors++;
      if (in_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL rnd_ready@%0d: got %b want %b", cyc, in_ready, exp_ready);
      end
      e.op  = op;
      e.res = golden(op, a, b, cin, m_acc);
      if (out_valid && out_ready) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL rnd_spurious@%0d: got result %h want none", cyc, sum);
        end else begin
          exp_t h;
          h = q.pop_front();
          if ({ovf, cout, sum} !== h.res) begin
            miscompares++;
            $display("FAIL rnd_result@%0d: got %h want %h", cyc, {ovf, cout, sum}, h.res);
          end
          if (h.op[1]) m_acc = h.res[W-1:0];
        end
      end
      if (in_valid && exp_ready) q.push_back(e);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      #1;
      if (out_valid) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL drain_spurious: got result %h want none", sum);
        end else begin
          exp_t h;
          h = q.pop_front();
          if ({ovf, cout, sum} !== h.res) begin
            miscompares++;
            $display("FAIL drain_result: got %h want %h", {ovf, cout, sum}, h.res);
          end
          if (h.op[1]) m_acc = h.res[W-1:0];
        end
      end
      tick();
    end
    vectors++;
    if (q.size() != 0) begin miscompares++; $display("FAIL drain_lost: got %0d pending want 0", q.size()); end
    vectors++;
    if (acc !== m_acc) begin miscompares++; $display("FAIL drain_acc: got %h want %h", acc, m_acc); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_acc_hazard();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/accumulator for the MAC datapath. It generalises the 4-bit lookahead adder to WIDTH bits built from 4-bit lookahead groups. Group carries are registered between STAGES pipeline stages. The block adds ADD/SUB/ACC/LOAD modes, a valid/ready handshake, back-pressure, and a hazard interlock on the internal accumulator. It sits between the partial-product reduction tree and the NPU output buffer.

## Interface
Parameters:
- WIDTH, 16, operand/result width; multiple of 4, ≥ 8.
- STAGES, 2, pipeline depth; must divide WIDTH/4. GPS = WIDTH/(4·STAGES) groups per stage.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- op  in  2  00 ADD, 01 SUB, 10 ACC, 11 LOAD.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B (ignored for ACC/LOAD).
- cin  in  1  carry-in (ADD only).
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB.
- ovf  out  1  two's-complement overflow.
- acc  out  WIDTH  current accumulator value.

## Operation
- Effective operands X, Y, c0 per op:
  - ADD: X=a, Y=b, c0=cin.
  - SUB: X=a, Y=~b, c0=1.
  - ACC: X=acc, Y=a, c0=0; X is sampled at acceptance.
  - LOAD: X=a, Y=0, c0=0.
- Stage s (0..STAGES-1) adds slice [4·GPS·(s+1)-1 : 4·GPS·s].
  - Slice is built from GPS 4-bit lookahead groups: P=x^y, G=x&y, full lookahead inside each group, group carry rippled to the next group within the stage.
  - Carry-in is c0 for s=0, otherwise the registered carry from stage s-1.
- Upper operand slices are skew-delayed into their stage; lower sum slices are deskewed so all WIDTH bits and op emerge together.
- sum = (X+Y+c0) mod 2^WIDTH. cout = carry out of bit WIDTH-1.
- ovf = (X[MSB]==Y[MSB]) && (sum[MSB]!=X[MSB]).
  - SUB: cout=1 means no borrow.
- Accumulator: acc ← sum when an ACC or LOAD result is transferred (out_valid && out_ready). ADD/SUB never change acc.
- Hazard interlock: in_ready=0 while offering ACC if any ACC or LOAD is in flight, including one held at the output. Other ops are never blocked by the hazard.
- Back-pressure: stall = out_valid && !out_ready freezes every stage register and the skew/deskew registers.
  - in_ready = !stall && !hazard.
  - Bubbles (valid=0) advance normally; the pipeline does not compress bubbles during a stall.

## Timing
- Latency: an operation accepted in cycle t has out_valid in cycle t+STAGES absent stall. Throughput 1 op/cycle.
- Outputs must hold stable while out_valid && !out_ready.
- Reset (async assert, any time including mid-operation): all stage valid bits 0, out_valid=0, sum=0, cout=0, ovf=0, acc=0. In-flight ops are discarded.
- in_ready is combinational from out_valid, out_ready, op, in_valid and in-flight tags; it is low during reset.
- Simultaneous ACC retirement and ACC offer in the same cycle: the offer is blocked that cycle and accepted the next cycle with the updated acc.
- Wrap: results are modulo 2^WIDTH; no saturation.

## Structure
- Shared package: op encoding constants (OP_ADD, OP_SUB, OP_ACC, OP_LOAD) and the parameter legality check (WIDTH%(4·STAGES)==0).
- One sub-module: cla_group4 (a, b, cin → s, cout; 4-bit full lookahead), instantiated WIDTH/4 times.
- Top level holds the stage registers, skew/deskew registers, accumulator and interlock.

## Test plan
All scenarios use WIDTH=16, STAGES=2.
- ADD a=16'h00FF, b=16'h0001, cin=0 → after 2 cycles sum=16'h0100, cout=0, ovf=0. Back-to-back stream of 8 ops → one result per cycle, in order.
- SUB a=16'h0000, b=16'h0001 → sum=16'hFFFF, cout=0. ADD a=16'h7FFF, b=16'h0001 → sum=16'h8000, ovf=1. ADD a=16'hFFFF, b=16'h0000, cin=1 → sum=16'h0000, cout=1 (carry across both stages).
- LOAD a=16'h0010, then ACC a=16'h0005 offered the next cycle → in_ready=0 until LOAD retires; final acc=16'h0015. An ADD in between is not blocked.
- Hold out_ready=0 for 3 cycles with 2 ops in flight → sum/cout/ovf stable, in_ready=0, no loss or duplication after release.
- Assert rst mid-stream with an ACC in flight → out_valid=0 and acc=0 immediately; the first op after reset deasserts behaves normally.
- Randomised ops over 10k cycles against a golden (X+Y+c0) model with random out_ready → zero mismatches.
